// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF compare controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ro_puf_pkg;

    localparam int SEL_W  = 5;   // RO mux select width (32 oscillators)
    localparam int CHAL_W = 10;  // challenge = {sel_b, sel_a}

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETTLE_A = 3'd1,
        COUNT_A  = 3'd2,
        SETTLE_B = 3'd3,
        COUNT_B  = 3'd4,
        COMPARE  = 3'd5,
        DONE     = 3'd6
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// 2-flop synchronizer plus rising-edge detector for the asynchronous RO output.
// Latency: an edge on async_in shows up as rise_pulse 2-3 clk cycles later.
// Backpressure: none; one pulse per detected rising edge.
// Ports: clk/rst (sync, active-high), async_in (RO mux output), rise_pulse (1-cycle pulse).
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise_pulse
);

    // [0] metastability flop, [1] synchronized value, [2] previous synchronized value
    logic [2:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], async_in};
        end
    end

    assign rise_pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/ro_compare_ctrl.sv
// RO-PUF controller: counts edges of RO A then RO B over fixed windows and compares.
// Latency: start sampled in cycle k gives done in cycle k + 2*(SETTLE_CYCLES+WIN_CYCLES) + 2.
// Backpressure: start is ignored while busy; nothing is queued.
// Ports: clk/rst (sync, active-high), start/challenge (request), ro_in (async RO),
//        sel (RO mux select), busy/done (status), response/tie/count_a/count_b (held results).
module ro_compare_ctrl
    import ro_puf_pkg::*;
#(
    parameter int WIN_CYCLES    = 256,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CHAL_W-1:0] challenge,
    input  logic              ro_in,
    output logic [SEL_W-1:0]  sel,
    output logic              busy,
    output logic              done,
    output logic              response,
    output logic              tie,
    output logic [CNT_W-1:0]  count_a,
    output logic [CNT_W-1:0]  count_b
);

    localparam int TMR_MAX = max_int(WIN_CYCLES, SETTLE_CYCLES);
    localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX + 1);
    // Timer is loaded with duration-1 and the state exits on the cycle it reads zero.
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] WIN_LD    = TMR_W'(WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   chal_b_q, chal_b_d;
    // Working counters accumulate during the windows; the visible count_* registers
    // only update in COMPARE so results stay stable between evaluations.
    logic [CNT_W-1:0]   cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0]   cnt_b_q, cnt_b_d;
    logic [CNT_W-1:0]   count_a_q, count_a_d;
    logic [CNT_W-1:0]   count_b_q, count_b_d;
    logic               resp_q, resp_d;
    logic               tie_q, tie_d;
    logic               rise;

    edge_sync u_edge_sync (
        .clk        (clk),
        .rst        (rst),
        .async_in   (ro_in),
        .rise_pulse (rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            sel_q     <= '0;
            chal_b_q  <= '0;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
            count_a_q <= '0;
            count_b_q <= '0;
            resp_q    <= 1'b0;
            tie_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            sel_q     <= sel_d;
            chal_b_q  <= chal_b_d;
            cnt_a_q   <= cnt_a_d;
            cnt_b_q   <= cnt_b_d;
            count_a_q <= count_a_d;
            count_b_q <= count_b_d;
            resp_q    <= resp_d;
            tie_q     <= tie_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        sel_d     = sel_q;
        chal_b_d  = chal_b_q;
        cnt_a_d   = cnt_a_q;
        cnt_b_d   = cnt_b_q;
        count_a_d = count_a_q;
        count_b_d = count_b_q;
        resp_d    = resp_q;
        tie_d     = tie_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    chal_b_d = challenge[2*SEL_W-1:SEL_W];
                    sel_d    = challenge[SEL_W-1:0];
                    cnt_a_d  = '0;
                    cnt_b_d  = '0;
                    timer_d  = SETTLE_LD;
                    state_d  = SETTLE_A;
                end
            end
            // Settle states let the mux output and the synchronizer pipeline flush;
            // any edge seen here belongs to the previous selection and is dropped.
            SETTLE_A: begin
                if (timer_q == '0) begin
                    timer_d = WIN_LD;
                    state_d = COUNT_A;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            COUNT_A: begin
                if (rise && (cnt_a_q != CNT_MAX)) begin
                    cnt_a_d = cnt_a_q + 1'b1;
                end
                if (timer_q == '0) begin
                    sel_d   = chal_b_q;
                    timer_d = SETTLE_LD;
                    state_d = SETTLE_B;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            SETTLE_B: begin
                if (timer_q == '0) begin
                    timer_d = WIN_LD;
                    state_d = COUNT_B;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            COUNT_B: begin
                if (rise && (cnt_b_q != CNT_MAX)) begin
                    cnt_b_d = cnt_b_q + 1'b1;
                end
                if (timer_q == '0) begin
                    state_d = COMPARE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            COMPARE: begin
                count_a_d = cnt_a_q;
                count_b_d = cnt_b_q;
                resp_d    = (cnt_a_q > cnt_b_q);
                tie_d     = (cnt_a_q == cnt_b_q);
                state_d   = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sel      = sel_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign response = resp_q;
    assign tie      = tie_q;
    assign count_a  = count_a_q;
    assign count_b  = count_b_q;

endmodule

// File: tb/tb_ro_compare_ctrl.sv
module tb_ro_compare_ctrl;

    localparam int WIN    = 16;
    localparam int SETTLE = 4;
    localparam int LAT    = 2 * (SETTLE + WIN) + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  challenge;
    logic        ro_in;
    logic        ro_in_s;

    logic [4:0]  sel, sel_s;
    logic        busy, busy_s, done, done_s;
    logic        response, response_s, tie, tie_s;
    logic [15:0] count_a, count_b;
    logic [1:0]  count_a_s, count_b_s;

    always #5 clk = ~clk;

    ro_compare_ctrl #(.WIN_CYCLES(WIN), .SETTLE_CYCLES(SETTLE), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .challenge(challenge), .ro_in(ro_in),
        .sel(sel), .busy(busy), .done(done), .response(response), .tie(tie),
        .count_a(count_a), .count_b(count_b)
    );

    // Narrow-counter instance used to observe saturation.
    ro_compare_ctrl #(.WIN_CYCLES(WIN), .SETTLE_CYCLES(SETTLE), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .start(start), .challenge(challenge), .ro_in(ro_in_s),
        .sel(sel_s), .busy(busy_s), .done(done_s), .response(response_s), .tie(tie_s),
        .count_a(count_a_s), .count_b(count_b_s)
    );

    // Oscillator bank: each RO is a square wave with a half-period in clk cycles
    // (0 = stuck low) and a phase offset. The mux model follows sel.
    int half [32];
    int phase[32];
    int cyc = 0;

    function automatic logic wave(input logic [4:0] s, input int c);
        if (half[s] == 0) return 1'b0;
        return (((c + phase[s]) / half[s]) % 2) == 1;
    endfunction

    always @(negedge clk) begin
        cyc     = cyc + 1;
        ro_in   = wave(sel, cyc);
        ro_in_s = wave(sel_s, cyc);
    end

    // Reference: a square wave of period 2*h dividing WIN has exactly WIN/(2*h)
    // rising edges in any WIN consecutive cycles.
    function automatic int exp_count(input int h);
        return (h == 0) ? 0 : WIN / (2 * h);
    endfunction

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    int n_vec = 0;
    int n_err = 0;
    int last_a = 0;
    int last_b = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "/busy"}, busy, 0);
        chk({tag, "/done"}, done, 0);
        chk({tag, "/sel"}, sel, 0);
        chk({tag, "/resp"}, response, 0);
        chk({tag, "/tie"}, tie, 0);
        chk({tag, "/cnt_a"}, count_a, 0);
        chk({tag, "/cnt_b"}, count_b, 0);
        chk({tag, "/cnt_a_s"}, count_a_s, 0);
    endtask

    // Starts one evaluation (start sampled at the first edge) and watches for
    // 'budget' edges. Optional re-pulse of start and reset pulse at given edges.
    task automatic run_eval(input string tag, input logic [4:0] a, input logic [4:0] b,
                            input int restart_at, input int rst_at, input int budget,
                            output int fd, output int nd, output int fds);
        bit aborted = 0;
        challenge = {b, a};
        start     = 1'b1;
        fd = -1; nd = 0; fds = -1;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) start = 1'b0;
            if (done) begin
                nd++;
                if (fd < 0) fd = n;
            end
            if (done_s && fds < 0) fds = n;
            if (!aborted) begin
                if (n == 10) begin
                    chk({tag, "/sel_a"}, sel, a);
                    chk({tag, "/busy"}, busy, 1);
                end
                if (n == 20) begin
                    chk({tag, "/hold_a"}, count_a, last_a);
                    chk({tag, "/hold_b"}, count_b, last_b);
                end
                if (n == 30) chk({tag, "/sel_b"}, sel, b);
            end
            if (restart_at > 0 && n == restart_at) start = 1'b1;
            if (restart_at > 0 && n == restart_at + 1) start = 1'b0;
            if (rst_at > 0 && n == rst_at) rst = 1'b1;
            if (rst_at > 0 && n == rst_at + 1) begin
                chk_zero({tag, "/post_rst"});
                rst = 1'b0;
                aborted = 1;
            end
        end
    endtask

    task automatic check_eval(input string tag, input int fd, input int nd, input int fds,
                              input int ea, input int eb, input logic er, input logic et);
        chk({tag, "/latency"}, fd, LAT);
        chk({tag, "/n_done"}, nd, 1);
        chk({tag, "/latency_s"}, fds, LAT);
        chk({tag, "/cnt_a"}, count_a, ea);
        chk({tag, "/cnt_b"}, count_b, eb);
        chk({tag, "/resp"}, response, er);
        chk({tag, "/tie"}, tie, et);
        chk({tag, "/cnt_a_s"}, count_a_s, sat3(ea));
        chk({tag, "/cnt_b_s"}, count_b_s, sat3(eb));
        chk({tag, "/resp_s"}, response_s, sat3(ea) > sat3(eb));
        chk({tag, "/tie_s"}, tie_s, sat3(ea) == sat3(eb));
        chk({tag, "/idle"}, busy, 0);
        last_a = ea;
        last_b = eb;
    endtask

    typedef struct {
        logic [4:0] a;
        logic [4:0] b;
        int         ha;
        int         hb;
        int         exp_a;
        int         exp_b;
        logic       exp_resp;
        logic       exp_tie;
    } vec_t;

    vec_t tbl[6];
    int   pick[5];

    task automatic randomize_bank();
        for (int j = 0; j < 32; j++) begin
            half[j]  = pick[$urandom_range(0, 4)];
            phase[j] = $urandom_range(0, 15);
        end
    endtask

    initial begin
        int fd, nd, fds, d1, d2, ea, eb;
        logic [4:0] ra, rb;

        pick[0] = 0; pick[1] = 1; pick[2] = 2; pick[3] = 4; pick[4] = 8;
        tbl[0] = '{a: 5'd3,  b: 5'd7,  ha: 4, hb: 8, exp_a: 2, exp_b: 1, exp_resp: 1'b1, exp_tie: 1'b0};
        tbl[1] = '{a: 5'd5,  b: 5'd5,  ha: 4, hb: 4, exp_a: 2, exp_b: 2, exp_resp: 1'b0, exp_tie: 1'b1};
        tbl[2] = '{a: 5'd0,  b: 5'd31, ha: 1, hb: 2, exp_a: 8, exp_b: 4, exp_resp: 1'b1, exp_tie: 1'b0};
        tbl[3] = '{a: 5'd1,  b: 5'd2,  ha: 0, hb: 8, exp_a: 0, exp_b: 1, exp_resp: 1'b0, exp_tie: 1'b0};
        tbl[4] = '{a: 5'd10, b: 5'd11, ha: 2, hb: 2, exp_a: 4, exp_b: 4, exp_resp: 1'b0, exp_tie: 1'b1};
        tbl[5] = '{a: 5'd20, b: 5'd9,  ha: 8, hb: 1, exp_a: 1, exp_b: 8, exp_resp: 1'b0, exp_tie: 1'b0};

        rst = 1'b1;
        start = 1'b0;
        challenge = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven vectors.
        for (int i = 0; i < 6; i++) begin
            randomize_bank();
            half[tbl[i].a] = tbl[i].ha;
            half[tbl[i].b] = tbl[i].hb;
            run_eval($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, 0, 0, LAT + 2, fd, nd, fds);
            check_eval($sformatf("tbl%0d", i), fd, nd, fds, tbl[i].exp_a, tbl[i].exp_b,
                       tbl[i].exp_resp, tbl[i].exp_tie);
        end

        // Second start 10 cycles in: ignored, results belong to the first challenge.
        randomize_bank();
        half[3] = 4; half[7] = 8; half[12] = 1;
        run_eval("restart", 5'd3, 5'd7, 10, 0, LAT + 20, fd, nd, fds);
        check_eval("restart", fd, nd, fds, 2, 1, 1'b1, 1'b0);

        // Reset during COUNT_B aborts with no done; the next run is normal.
        run_eval("rst_mid", 5'd3, 5'd7, 0, 30, LAT + 10, fd, nd, fds);
        chk("rst_mid/n_done", nd, 0);
        last_a = 0;
        last_b = 0;
        run_eval("after_rst", 5'd3, 5'd7, 0, 0, LAT + 2, fd, nd, fds);
        check_eval("after_rst", fd, nd, fds, 2, 1, 1'b1, 1'b0);

        // start held high: back-to-back evaluations, the second begins on the
        // first IDLE cycle after DONE.
        challenge = {5'd7, 5'd3};
        start = 1'b1;
        d1 = -1;
        d2 = -1;
        for (int n = 1; n <= 2 * LAT + 6; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (d1 < 0) d1 = n;
                else if (d2 < 0) d2 = n;
            end
            if (n == 2 * LAT + 1) start = 1'b0;
        end
        chk("held/first_done", d1, LAT);
        chk("held/second_done", d2, 2 * LAT + 1);
        chk("held/idle", busy, 0);

        // Randomized oscillator banks and challenges against the reference.
        for (int i = 0; i < 12; i++) begin
            randomize_bank();
            ra = 5'($urandom_range(0, 31));
            rb = 5'($urandom_range(0, 31));
            ea = exp_count(half[ra]);
            eb = exp_count(half[rb]);
            run_eval($sformatf("rnd%0d", i), ra, rb, 0, 0, LAT + 2, fd, nd, fds);
            check_eval($sformatf("rnd%0d", i), fd, nd, fds, ea, eb, ea > eb, ea == eb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ro_compare_ctrl.md
RO_COMPARE_CTRL -- requirements
Module: ro_compare_ctrl

Interface
REQ-001 Parameter WIN_CYCLES, default 256: number of clk cycles in each counting window.
REQ-002 Parameter SETTLE_CYCLES, default 4: number of clk cycles to wait after a sel change before counting starts.
REQ-003 Parameter CNT_W, default 16: width of the edge counters.
REQ-004 clk  input  1  single system clock; the block has one clock.
REQ-005 rst  input  1  reset, synchronous to clk, active-high.
REQ-006 start  input  1  request to evaluate one challenge; sampled only in IDLE.
REQ-007 challenge  input  10  [4:0] selects RO A and [9:5] selects RO B; captured when start is accepted.
REQ-008 ro_in  input  1  selected ring-oscillator output from the 32:1 RO mux; asynchronous to clk.
REQ-009 sel  output  5  drives the RO mux select input.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse marking a valid result.
REQ-012 response  output  1  PUF response bit.
REQ-013 tie  output  1  high when count_a equals count_b.
REQ-014 count_a / count_b  output  CNT_W each  window edge counts for RO A and RO B.

Function
REQ-015 ro_in SHALL pass through a 2-flop synchronizer followed by a rising-edge detector; one detected edge adds 1 to the active counter.
REQ-016 FSM states SHALL be IDLE, SETTLE_A, COUNT_A, SETTLE_B, COUNT_B, COMPARE, DONE.
REQ-017 IDLE with start=1 SHALL capture challenge, set sel to challenge[4:0], clear both counters and go to SETTLE_A.
REQ-018 SETTLE_A SHALL last SETTLE_CYCLES cycles, then go to COUNT_A; edges detected during SETTLE_A SHALL be discarded.
REQ-019 COUNT_A SHALL last exactly WIN_CYCLES cycles and count edges into count_a; on exit, sel SHALL change to the captured challenge[9:5] and the FSM SHALL go to SETTLE_B.
REQ-020 SETTLE_B and COUNT_B SHALL behave like SETTLE_A and COUNT_A, but the count goes into count_b.
REQ-021 COMPARE SHALL last one cycle and register the results:
- response = 1 if count_a > count_b, else 0;
- tie = 1 if count_a == count_b.
REQ-022 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-023 Latency: start accepted at edge k gives done=1 in cycle k + 2*(SETTLE_CYCLES+WIN_CYCLES) + 2.
REQ-024 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-025 start asserted while busy=1 SHALL be ignored; it SHALL NOT be queued.
REQ-026 start held high continuously SHALL start a new evaluation on the first cycle back in IDLE.
REQ-027 challenge[4:0] == challenge[9:5] is legal: the full sequence SHALL still run.
REQ-028 response, tie, count_a and count_b SHALL hold their values from the last COMPARE until the next COMPARE.
REQ-029 A timer counter sized to max(WIN_CYCLES, SETTLE_CYCLES) SHALL time the SETTLE and COUNT states and SHALL reload on every state entry.

Reset
REQ-030 rst=1 at any clock edge SHALL force:
- state=IDLE, sel=0, busy=0, done=0, response=0, tie=0;
- count_a=0, count_b=0, timer=0, synchronizer flops=0.
REQ-031 Reset asserted mid-evaluation SHALL abort the evaluation with no done pulse; the next start after reset releases SHALL run a full sequence.

Structure
REQ-032 A shared package ro_puf_pkg SHALL hold:
- the FSM state enum;
- the constants SEL_W=5 and CHAL_W=10.
REQ-033 A single sub-module edge_sync SHALL contain the 2-flop synchronizer and the rising-edge detector, with ports clk, rst, async_in and rise_pulse.

Verification
All scenarios use WIN_CYCLES=16 and SETTLE_CYCLES=4. The bench models the mux by driving ro_in according to sel.
REQ-034 Challenge A=3, B=7; RO3 toggles with an 8-cycle period and RO7 with a 16-cycle period -> count_a=2, count_b=1, response=1, tie=0, done exactly 42 cycles after start.
REQ-035 Challenge A=5, B=5, same 8-cycle source -> count_a=count_b=2, tie=1, response=0.
REQ-036 Second start pulse 10 cycles after the first -> exactly one done pulse, and the results match the first challenge only.
REQ-037 rst pulsed during COUNT_B -> no done pulse, all outputs zero, busy=0; a later start completes normally.
REQ-038 CNT_W=2 with RO A toggling on every clk edge -> count_a saturates at 3 and does not wrap.
